// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch: accepts one PC, reads the word over AXI4-Lite and holds it for decode.
// Latency from accept to Ivalid is 3 cycles plus bus waits (1 if misaligned); Ivalid/Inst/InstPC/Ierr hold until Dready.
module ysyx_23060184_ifu #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] RESP_OKAY  = 2'b00
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  Pvalid,
    output logic                  Iready,
    input  logic [DATA_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  Ivalid,
    input  logic                  Dready,
    output logic [DATA_WIDTH-1:0] Inst,
    output logic [DATA_WIDTH-1:0] InstPC,
    output logic                  Ierr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  ierr_q, ierr_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            ierr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ierr_q  <= ierr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ierr_d  = ierr_q;
        case (state_q)
            IDLE: begin
                if (Pvalid) begin
                    pc_d = PC;
                    if (PC[1:0] == 2'b00) begin
                        state_d = AR;
                    end else begin
                        // Misaligned PC faults locally without touching the bus
                        inst_d  = '0;
                        ierr_d  = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            AR: begin
                if (arready) state_d = R;
            end
            R: begin
                if (rvalid) begin
                    inst_d  = rdata;
                    ierr_d  = (rresp != RESP_OKAY);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Dready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode state only, so no input reaches an output combinationally
    assign Iready  = (state_q == IDLE);
    assign arvalid = (state_q == AR);
    assign rready  = (state_q == R);
    assign Ivalid  = (state_q == HOLD);
    assign araddr  = ADDR_WIDTH'(pc_q);
    assign InstPC  = pc_q;
    assign Inst    = inst_q;
    assign Ierr    = ierr_q;

endmodule

// File: doc/ysyx_23060184_ifu.md
# ysyx_23060184_ifu

Instruction fetch unit for the ysyx_23060184 multi-cycle core. It is the consumer side of the PC unit's `Pvalid`/`Iready` handshake: it accepts one PC, fetches the 32-bit instruction word over an AXI4-Lite read channel, and presents the word to decode with a `Ivalid`/`Dready` handshake. At most one fetch is outstanding at a time.

## Interface
- `DATA_WIDTH`, 32: instruction, PC and read-data width.
- `ADDR_WIDTH`, 32: AXI read address width.
- `RESP_OKAY`, 2'b00: the only `rresp` value treated as success.

- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `Pvalid`  in  1  PC unit has a valid PC.
- `Iready`  out  1  IFU can accept a PC.
- `PC`  in  DATA_WIDTH  fetch address; sampled only on acceptance.
- `araddr`  out  ADDR_WIDTH  AXI read address.
- `arvalid`  out  1  AXI read address valid.
- `arready`  in  1  AXI read address ready.
- `rdata`  in  DATA_WIDTH  AXI read data.
- `rresp`  in  2  AXI read response.
- `rvalid`  in  1  AXI read data valid.
- `rready`  out  1  AXI read data ready.
- `Ivalid`  out  1  `Inst`/`InstPC`/`Ierr` valid for decode.
- `Dready`  in  1  decode accepts the instruction.
- `Inst`  out  DATA_WIDTH  fetched instruction word.
- `InstPC`  out  DATA_WIDTH  PC of `Inst`.
- `Ierr`  out  1  fetch fault: misaligned PC or non-OKAY `rresp`.

## Operation
- FSM states: IDLE, AR, R, HOLD. All outputs are registered or decoded from state only. No combinational path runs from any input to any output.
- IDLE:
  - `Iready`=1.
  - On `Pvalid && Iready`, latch `PC` into the PC register.
  - If `PC[1:0]==0`, go to AR.
  - Otherwise load `Inst`=0 and `Ierr`=1, and go directly to HOLD. No bus access is issued.
- AR:
  - `arvalid`=1 and `araddr`=latched PC.
  - Both signals stay stable until `arready`.
  - On `arvalid && arready`, go to R.
- R:
  - `rready`=1.
  - On `rvalid`, capture `Inst`=`rdata` and `Ierr`=(`rresp`!=`RESP_OKAY`), then go to HOLD.
  - `rvalid` that arrives before R is never sampled. The slave holds it per AXI rules.
- HOLD:
  - `Ivalid`=1. `Inst`, `InstPC` and `Ierr` stay stable.
  - On `Dready`, go to IDLE.
- `InstPC` always equals the PC latched for the current fetch.
- `Pvalid` and `PC` are ignored outside IDLE.
- `Dready` is ignored outside HOLD.
- Exactly one of `Iready`, `arvalid`, `rready`, `Ivalid` is high in any cycle.
- Reset value of every output:
  - `Iready`=1, state IDLE.
  - `arvalid`=0, `rready`=0, `Ivalid`=0, `Ierr`=0.
  - `araddr`=0, `Inst`=0, `InstPC`=0.
- Reset mid-operation: asynchronous return to IDLE with the reset values above. Any in-flight AXI transaction is abandoned; the memory is reset by the same `rstn`.

## Timing
- Edge 0: PC accepted (`Pvalid && Iready`). `Iready` drops after edge 0.
- Cycle 1: `arvalid`=1.
- Fastest case (`arready` in cycle 1, `rvalid` in cycle 2): `Ivalid`=1 in cycle 3.
- Latency from acceptance to `Ivalid` is 3 + AR wait cycles + R wait cycles.
- Misaligned PC: `Ivalid`=1 in cycle 1.
- `Iready` returns to 1 in the cycle after `Ivalid && Dready`.
- Maximum throughput is one instruction per 4 cycles (accept, AR, R, HOLD).
- Simultaneous `arready` and `rvalid` in the AR cycle: only `arready` is acted on. `rvalid` is taken in the following R cycle.

## Test plan
- Reset, then `Pvalid`=1, `PC`=0x80000000, memory returns 0x00000413 with zero wait states:
  - `arvalid` with `araddr`=0x80000000 in cycle 1.
  - `Ivalid`=1, `Inst`=0x00000413, `InstPC`=0x80000000, `Ierr`=0 in cycle 3.
- Same fetch with `arready` delayed 3 cycles and `rvalid` delayed 2 cycles:
  - `araddr` and `arvalid` stay stable through the AR wait.
  - `Ivalid` rises in cycle 8.
  - No early `rready`.
- `Dready`=0 held for 5 cycles in HOLD:
  - `Ivalid`, `Inst` and `InstPC` stay constant.
  - `Iready`=0 throughout.
  - A new `Pvalid`/`PC` presented meanwhile is ignored.
- `PC`=0x80000002:
  - No `arvalid`.
  - `Ivalid`=1 in cycle 1 with `Ierr`=1, `Inst`=0, `InstPC`=0x80000002.
- `rresp`=2'b10 (SLVERR) with `rdata`=0xDEADBEEF:
  - `Ierr`=1 and `Inst`=0xDEADBEEF.
  - The next fetch with OKAY clears `Ierr` to 0.
- `rstn` asserted asynchronously while in R (mid-cycle, between edges):
  - `rready` drops immediately; state returns to IDLE with all outputs at reset values.
  - After release, a fresh fetch of 0x80000004 completes normally.
